// File: rtl/data_display_pkg.sv
// Shared types and constants for the divider front-panel display.
// Select codes, segment patterns and the digit output bundle.
package data_display_pkg;

  typedef enum logic [1:0] {
    SEL_DIVIDEND  = 2'b00,
    SEL_DIVISOR   = 2'b01,
    SEL_QUOTIENT  = 2'b10,
    SEL_REMAINDER = 2'b11
  } data_sel_e;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  function automatic logic [3:0] nibble(
    input logic [15:0] v,
    input logic [1:0]  i
  );
    return v[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/data_display_seven_seg_decode.sv
// Hex digit to active-low 7-segment pattern, {g,f,e,d,c,b,a}.
// Purely combinational so the debug display can share it.
module seven_seg_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/data_display.sv
// Multiplexed 4-digit 7-segment driver for the divider panel.
// Shows operands or captured results, blinks the edited nibble.
module data_display
  import data_display_pkg::*;
#(
  parameter int REFRESH_CNT = 50000,
  parameter int BLINK_BITS  = 24
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  DATA_SELECT,
  input  logic [1:0]  BIT_SELECT,
  input  logic        OPERR,
  input  logic [15:0] DIVIDEND,
  input  logic [7:0]  DIVISOR,
  input  logic [15:0] QUOTIENT,
  input  logic [7:0]  REMAINDER,
  input  logic        RESULT_VALID,
  input  logic        DIV_BY_ZERO,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int PW =
    (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST =
    PW'(REFRESH_CNT - 1);

  logic [PW-1:0]         presc;
  logic [1:0]            idx;
  logic [BLINK_BITS-1:0] blk;
  logic                  tc;

  logic        res_valid;
  logic [15:0] q_cap;
  logic [7:0]  r_cap;
  logic        err_cap;
  logic [15:0] snap_dd;
  logic [7:0]  snap_dr;
  logic        held;

  data_sel_e  sel;
  logic       sel_hi;
  logic [3:0] nib;
  logic       blank_pos;
  logic [6:0] dec_seg;
  disp_t      nxt;

  assign tc     = (presc == PRESC_LAST);
  assign sel    = data_sel_e'(DATA_SELECT);
  assign sel_hi = DATA_SELECT[1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
      idx   <= '0;
      blk   <= '0;
    end else begin
      blk <= blk + 1'b1;
      if (tc) begin
        presc <= '0;
        idx   <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      res_valid <= 1'b0;
      q_cap     <= '0;
      r_cap     <= '0;
      err_cap   <= 1'b0;
      snap_dd   <= '0;
      snap_dr   <= '0;
    end else if (RESULT_VALID) begin
      res_valid <= 1'b1;
      q_cap     <= QUOTIENT;
      r_cap     <= REMAINDER;
      err_cap   <= DIV_BY_ZERO;
      snap_dd   <= DIVIDEND;
      snap_dr   <= DIVISOR;
    end
  end

  // Any operand edit since capture makes the result stale.
  assign held = res_valid
             && (DIVIDEND == snap_dd)
             && (DIVISOR == snap_dr);

  always_comb begin
    nib       = '0;
    blank_pos = 1'b0;
    unique case (sel)
      SEL_DIVIDEND: nib = nibble(DIVIDEND, idx);
      SEL_DIVISOR: begin
        nib       = nibble({8'h00, DIVISOR}, idx);
        blank_pos = idx[1];
      end
      SEL_QUOTIENT: nib = nibble(q_cap, idx);
      SEL_REMAINDER: begin
        nib       = nibble({8'h00, r_cap}, idx);
        blank_pos = idx[1];
      end
    endcase
  end

  seven_seg_decode u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_comb begin
    nxt.an  = ~(4'b0001 << idx);
    nxt.dp  = ~OPERR;
    nxt.seg = dec_seg;
    if (sel_hi && !held) begin
      nxt.seg = SEG_DASH;
    end else if (sel_hi && err_cap) begin
      unique case (idx)
        2'd3: nxt.seg = SEG_E;
        2'd2: nxt.seg = SEG_R;
        2'd1: nxt.seg = SEG_R;
        2'd0: nxt.seg = SEG_BLANK;
      endcase
    end else if (blank_pos) begin
      nxt.seg = SEG_BLANK;
    end
    if (!sel_hi && !OPERR && idx == BIT_SELECT
        && blk[BLINK_BITS-1]) begin
      nxt.seg = SEG_BLANK;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AN  <= 4'hF;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else if (tc) begin
      AN  <= nxt.an;
      SEG <= nxt.seg;
      DP  <= nxt.dp;
    end
  end

endmodule

// File: tb/tb_data_display.sv
// Scoreboard bench for data_display with a 4-clock slot.
// Expected digit tuples are queued per scan and popped on update.
module tb_data_display;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  DATA_SELECT = '0;
  logic [1:0]  BIT_SELECT = '0;
  logic        OPERR = 1'b0;
  logic [15:0] DIVIDEND = '0;
  logic [7:0]  DIVISOR = '0;
  logic [15:0] QUOTIENT = '0;
  logic [7:0]  REMAINDER = '0;
  logic        RESULT_VALID = 1'b0;
  logic        DIV_BY_ZERO = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  data_display #(
    .REFRESH_CNT (4),
    .BLINK_BITS  (4)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DATA_SELECT  (DATA_SELECT),
    .BIT_SELECT   (BIT_SELECT),
    .OPERR        (OPERR),
    .DIVIDEND     (DIVIDEND),
    .DIVISOR      (DIVISOR),
    .QUOTIENT     (QUOTIENT),
    .REMAINDER    (REMAINDER),
    .RESULT_VALID (RESULT_VALID),
    .DIV_BY_ZERO  (DIV_BY_ZERO),
    .AN           (AN),
    .SEG          (SEG),
    .DP           (DP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Edges since reset release; digit updates land on multiples of 4.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (!RESET && cyc != 0 && cyc % 4 == 0 && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, "_an"}, 16'(AN), 16'(e.an));
      check({e.tag, "_seg"}, 16'(SEG), 16'(e.seg));
      check({e.tag, "_dp"}, 16'(DP), 16'(e.dp));
    end
  end

  task automatic scan(
    input string      tag,
    input logic [6:0] s0,
    input logic [6:0] s1,
    input logic [6:0] s2,
    input logic [6:0] s3,
    input logic       dp
  );
    logic [6:0] s [4];
    bit done;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      if (cyc % 16 == 1) break;
    end
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e.tag = $sformatf("%s_d%0d", tag, d);
      e.an  = ~(4'b0001 << d);
      e.seg = s[d];
      e.dp  = dp;
      q.push_back(e);
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (q.size() == 0) done = 1;
    end
    if (!done) begin
      check({tag, "_timeout"}, 16'(q.size()), 16'd0);
      q.delete();
    end
  endtask

  task automatic pulse(
    input logic [15:0] qv,
    input logic [7:0]  rv,
    input logic        dz
  );
    @(negedge CLK);
    QUOTIENT     = qv;
    REMAINDER    = rv;
    DIV_BY_ZERO  = dz;
    RESULT_VALID = 1'b1;
    @(negedge CLK);
    RESULT_VALID = 1'b0;
    DIV_BY_ZERO  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_an", 16'(AN), 16'hF);
    check("rst_seg", 16'(SEG), 16'h7F);
    check("rst_dp", 16'(DP), 16'h1);
    DIVIDEND = 16'h1234;
    DIVISOR  = 8'hA5;
    RESET    = 1'b0;

    scan("dd", 7'h19, 7'h30, 7'h24, 7'h79, 1'b1);
    BIT_SELECT = 2'd2;
    scan("dd_blink", 7'h19, 7'h30, 7'h7F, 7'h79, 1'b1);
    DATA_SELECT = 2'd1;
    BIT_SELECT  = 2'd1;
    scan("dr", 7'h12, 7'h08, 7'h7F, 7'h7F, 1'b1);
    DATA_SELECT = 2'd2;
    BIT_SELECT  = 2'd3;
    scan("q_none", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    pulse(16'h00C8, 8'h0F, 1'b0);
    scan("q", 7'h00, 7'h46, 7'h40, 7'h40, 1'b1);
    DATA_SELECT = 2'd3;
    scan("r", 7'h0E, 7'h40, 7'h7F, 7'h7F, 1'b1);

    DIVIDEND    = 16'h1235;
    DATA_SELECT = 2'd2;
    scan("q_stale", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    @(negedge CLK);
    DIVIDEND     = 16'h5000;
    QUOTIENT     = 16'hBEEF;
    REMAINDER    = 8'h00;
    RESULT_VALID = 1'b1;
    @(negedge CLK);
    RESULT_VALID = 1'b0;
    scan("q_same", 7'h0E, 7'h06, 7'h06, 7'h03, 1'b1);

    pulse(16'h0000, 8'h00, 1'b1);
    scan("q_dz", 7'h7F, 7'h2F, 7'h2F, 7'h06, 1'b1);
    DATA_SELECT = 2'd3;
    scan("r_dz", 7'h7F, 7'h2F, 7'h2F, 7'h06, 1'b1);

    OPERR       = 1'b1;
    DATA_SELECT = 2'd1;
    BIT_SELECT  = 2'd3;
    scan("operr_dr", 7'h12, 7'h08, 7'h7F, 7'h7F, 1'b0);
    DATA_SELECT = 2'd0;
    BIT_SELECT  = 2'd2;
    scan("operr_dd", 7'h40, 7'h40, 7'h40, 7'h12, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (cyc % 4 == 2) break;
    end
    check("pre_rst_an_active", 16'(AN != 4'hF), 16'h1);
    RESET = 1'b1;
    #1;
    check("midrst_an", 16'(AN), 16'hF);
    check("midrst_seg", 16'(SEG), 16'h7F);
    check("midrst_dp", 16'(DP), 16'h1);
    @(negedge CLK);
    OPERR       = 1'b0;
    DATA_SELECT = 2'd2;
    RESET       = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_idle_an", 16'(AN), 16'hF);
    scan("post_rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
